// File: rtl/relu_requant_stage.sv
// Multi-lane activation + requantise/saturate output stage: two-deep elastic pipeline with run/drain/done control.
// Optional: define RELU_REQUANT_ROUND_EN for round-half-up requantisation (default truncates toward -inf).

module relu_act_lane #(
    parameter int IN_W = 25,
    parameter int SH_W = 4
) (
    input  logic signed [IN_W-1:0] x_i,
    input  logic        [1:0]      mode_i,
    input  logic        [SH_W-1:0] leak_shift_i,
    output logic signed [IN_W-1:0] a_o
);
    always_comb begin
        a_o = x_i;
        if (x_i[IN_W-1]) begin
            case (mode_i)
                2'b01, 2'b11: a_o = '0;
                // Oversized shifts sign-fill, so large leak_shift settles at -1.
                2'b10:        a_o = x_i >>> leak_shift_i;
                default:      a_o = x_i;
            endcase
        end
    end
endmodule

module requant_sat_lane #(
    parameter int IN_W      = 25,
    parameter int OUT_W     = 16,
    parameter int RQ_SHIFT  = 4,
    parameter int CLAMP_MAX = 255
) (
    input  logic signed [IN_W-1:0]  a_i,
    input  logic                    clamp_i,
    output logic signed [OUT_W-1:0] y_o,
    output logic                    sat_o
);
    localparam int XW = IN_W + 1;
`ifdef RELU_REQUANT_ROUND_EN
    localparam logic signed [XW-1:0] RND = XW'((2 ** RQ_SHIFT) / 2);
`else
    localparam logic signed [XW-1:0] RND = '0;
`endif
    localparam logic signed [XW-1:0] OMAX = XW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [XW-1:0] OMIN = ~OMAX;
    localparam logic signed [XW-1:0] CMAX = XW'(CLAMP_MAX);

    logic signed [XW-1:0] ext, shf, v;

    // One extra bit of headroom keeps the rounding add from overflowing.
    assign ext = XW'(a_i);
    assign shf = (ext + RND) >>> RQ_SHIFT;

    always_comb begin
        v     = shf;
        sat_o = 1'b0;
        if (clamp_i && (v > CMAX)) begin
            v     = CMAX;
            sat_o = 1'b1;
        end
        if (v > OMAX) begin
            v     = OMAX;
            sat_o = 1'b1;
        end else if (v < OMIN) begin
            v     = OMIN;
            sat_o = 1'b1;
        end
        y_o = v[OUT_W-1:0];
    end
endmodule

module relu_requant_stage #(
    parameter int CH        = 2,
    parameter int IN_W      = 25,
    parameter int OUT_W     = 16,
    parameter int RQ_SHIFT  = 4,
    parameter int SH_W      = 4,
    parameter int CLAMP_MAX = 255,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_conv,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic [SH_W-1:0]       leak_shift,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_data,
    output logic [CH-1:0]         sat_flag,
    output logic [CNT_W-1:0]      out_count,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    state_e state_q, state_d;

    logic                      s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [CH-1:0][IN_W-1:0]   in_lanes, act, s1_data_q;
    logic [1:0]                s1_mode_q;
    logic [CH-1:0][OUT_W-1:0]  rq, s2_data_q;
    logic [CH-1:0]             rq_sat, s2_sat_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      s1_ld, s2_ld, accept, deliver;

    assign in_lanes = in_data;
    assign s2_ld    = !s2_vld_q || out_ready;
    assign s1_ld    = !s1_vld_q || s2_ld;
    assign in_ready = (state_q == RUN) && s1_ld && !clear;
    assign accept   = in_valid && in_ready;
    assign deliver  = s2_vld_q && out_ready;

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        relu_act_lane #(.IN_W(IN_W), .SH_W(SH_W)) u_act (
            .x_i          (in_lanes[gi]),
            .mode_i       (mode),
            .leak_shift_i (leak_shift),
            .a_o          (act[gi])
        );
        requant_sat_lane #(
            .IN_W(IN_W), .OUT_W(OUT_W), .RQ_SHIFT(RQ_SHIFT), .CLAMP_MAX(CLAMP_MAX)
        ) u_rq (
            .a_i     (s1_data_q[gi]),
            .clamp_i (s1_mode_q == 2'b11),
            .y_o     (rq[gi]),
            .sat_o   (rq_sat[gi])
        );
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        if (s2_ld) s2_vld_d = s1_vld_q;
        if (s1_ld) s1_vld_d = accept;
        if (clear) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end
    end

    // DRAIN looks at next-cycle occupancy so done lands the cycle after the final handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_conv) state_d = RUN;
            RUN:     if (!start_conv) state_d = DRAIN;
            DRAIN:   if (!s1_vld_d && !s2_vld_d) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_mode_q <= '0;
            s2_data_q <= '0;
            s2_sat_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            if (accept) begin
                s1_data_q <= act;
                s1_mode_q <= mode;
            end
            if (clear) begin
                s2_data_q <= '0;
                s2_sat_q  <= '0;
                cnt_q     <= '0;
            end else begin
                if (s2_ld && s1_vld_q) begin
                    s2_data_q <= rq;
                    s2_sat_q  <= rq_sat;
                end
                if (deliver) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = s2_vld_q;
    assign out_data  = s2_data_q;
    assign sat_flag  = s2_sat_q;
    assign out_count = cnt_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_relu_requant_stage.sv
// Directed self-checking bench for relu_requant_stage (default parameters).
module tb_relu_requant_stage;
    localparam int CH = 2, IN_W = 25, OUT_W = 16, SH_W = 4, CNT_W = 16;

    logic clk = 1'b0, rst_n = 1'b1;
    logic start_conv = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic [SH_W-1:0]     leak_shift = '0;
    logic [CH*IN_W-1:0]  in_data = '0;
    logic                in_ready, out_valid, done;
    logic [CH*OUT_W-1:0] out_data;
    logic [CH-1:0]       sat_flag;
    logic [CNT_W-1:0]    out_count;

    int nvec = 0, nerr = 0;

    relu_requant_stage dut (
        .clk(clk), .rst_n(rst_n), .start_conv(start_conv), .clear(clear),
        .mode(mode), .leak_shift(leak_shift), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .out_count(out_count), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [CH*IN_W-1:0] pk(input int l0, input int l1);
        pk = {IN_W'(l1), IN_W'(l0)};
    endfunction

    function automatic logic [CH*OUT_W-1:0] po(input int l0, input int l1);
        po = {OUT_W'(l1), OUT_W'(l0)};
    endfunction

    // Offers one beat with out_ready=1, returns the output and accept-to-valid latency (-1 if none).
    task automatic xfer(input logic [CH*IN_W-1:0] d, input logic [1:0] m, input logic [SH_W-1:0] ls,
                        output logic [CH*OUT_W-1:0] od, output logic [CH-1:0] sf, output int lat);
        bit ok;
        ok = 0; lat = -1; od = '0; sf = '0;
        @(posedge clk); #1;
        in_data = d; mode = m; leak_shift = ls; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; mode = 2'b00; leak_shift = '0;
        if (ok) begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (out_valid) begin lat = k; od = out_data; sf = sat_flag; break; end
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        nvec++; if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            nerr++; $display("FAIL reset_ctl: got v=%b d=%b r=%b, expected 0 0 0", out_valid, done, in_ready); end
        nvec++; if (out_data !== '0 || sat_flag !== '0 || out_count !== '0) begin
            nerr++; $display("FAIL reset_data: got %h %b %0d, expected 0 0 0", out_data, sat_flag, out_count); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_relu();
        logic [CH*OUT_W-1:0] od, e; logic [CH-1:0] sf; int lat;
        @(posedge clk); #1 start_conv = 1'b1;
        xfer(pk(-100, 1000), 2'b01, 0, od, sf, lat);
`ifdef RELU_REQUANT_ROUND_EN
        e = po(0, 63);
`else
        e = po(0, 62);
`endif
        nvec++; if (lat !== 2) begin nerr++; $display("FAIL relu_lat: got %0d, expected 2", lat); end
        nvec++; if (od !== e) begin nerr++; $display("FAIL relu_data: got %h, expected %h", od, e); end
        nvec++; if (sf !== 2'b00) begin nerr++; $display("FAIL relu_sat: got %b, expected 00", sf); end
    endtask

    task automatic test_saturation();
        logic [CH*OUT_W-1:0] od; logic [CH-1:0] sf; int lat;
        xfer(pk(-2000000, 2000000), 2'b00, 0, od, sf, lat);
        nvec++; if (od !== po(-32768, 32767)) begin nerr++; $display("FAIL sat_big: got %h, expected %h", od, po(-32768, 32767)); end
        nvec++; if (sf !== 2'b11) begin nerr++; $display("FAIL sat_big_flag: got %b, expected 11", sf); end
        xfer(pk(-524288, 524272), 2'b00, 0, od, sf, lat);
        nvec++; if (od !== po(-32768, 32767)) begin nerr++; $display("FAIL sat_edge_in: got %h, expected %h", od, po(-32768, 32767)); end
        nvec++; if (sf !== 2'b00) begin nerr++; $display("FAIL sat_edge_in_flag: got %b, expected 00", sf); end
        xfer(pk(-524304, 524288), 2'b00, 0, od, sf, lat);
        nvec++; if (od !== po(-32768, 32767)) begin nerr++; $display("FAIL sat_edge_out: got %h, expected %h", od, po(-32768, 32767)); end
        nvec++; if (sf !== 2'b11) begin nerr++; $display("FAIL sat_edge_out_flag: got %b, expected 11", sf); end
    endtask

    task automatic test_leaky();
        logic [CH*OUT_W-1:0] od, e; logic [CH-1:0] sf; int lat;
        xfer(pk(-800, 64), 2'b10, 3, od, sf, lat);
`ifdef RELU_REQUANT_ROUND_EN
        e = po(-6, 4);
`else
        e = po(-7, 4);
`endif
        nvec++; if (od !== e) begin nerr++; $display("FAIL leaky3: got %h, expected %h", od, e); end
        nvec++; if (sf !== 2'b00) begin nerr++; $display("FAIL leaky3_flag: got %b, expected 00", sf); end
        xfer(pk(-800, 1000), 2'b10, 15, od, sf, lat);
`ifdef RELU_REQUANT_ROUND_EN
        e = po(0, 63);
`else
        e = po(-1, 62);
`endif
        nvec++; if (od !== e) begin nerr++; $display("FAIL leaky15: got %h, expected %h", od, e); end
    endtask

    task automatic test_clamp();
        logic [CH*OUT_W-1:0] od; logic [CH-1:0] sf; int lat;
        xfer(pk(-5000, 8000), 2'b11, 0, od, sf, lat);
        nvec++; if (od !== po(0, 255)) begin nerr++; $display("FAIL clamp: got %h, expected %h", od, po(0, 255)); end
        nvec++; if (sf !== 2'b10) begin nerr++; $display("FAIL clamp_flag: got %b, expected 10", sf); end
        xfer(pk(4080, 8000), 2'b11, 0, od, sf, lat);
        nvec++; if (od !== po(255, 255)) begin nerr++; $display("FAIL clamp_edge: got %h, expected %h", od, po(255, 255)); end
        nvec++; if (sf !== 2'b10) begin nerr++; $display("FAIL clamp_edge_flag: got %b, expected 10", sf); end
    endtask

    task automatic test_backpressure();
        logic [CH*OUT_W-1:0] got [4];
        int idx, n; logic acc;
        idx = 0; n = 0;
        @(posedge clk); #1 clear = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 clear = 1'b0;
        in_valid = 1'b1; mode = 2'b00; in_data = pk(16, -16);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (c == 0) begin
                nvec++; if (out_count !== '0) begin nerr++; $display("FAIL bp_clear_cnt: got %0d, expected 0", out_count); end
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) in_data = pk(16 * (idx + 1), -16 * (idx + 1)); else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        nvec++; if (idx !== 2) begin nerr++; $display("FAIL bp_held: got %0d accepted, expected 2", idx); end
        nvec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            nerr++; $display("FAIL bp_stall: got ready=%b valid=%b, expected 0 1", in_ready, out_valid); end
        nvec++; if (out_data !== po(1, -1)) begin nerr++; $display("FAIL bp_head: got %h, expected %h", out_data, po(1, -1)); end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin got[n] = out_data; n++; end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) in_data = pk(16 * (idx + 1), -16 * (idx + 1)); else in_valid = 1'b0;
            end
        end
        nvec++; if (n !== 4) begin nerr++; $display("FAIL bp_count: got %0d beats, expected 4", n); end
        for (int k = 0; k < n; k++) begin
            nvec++; if (got[k] !== po(k + 1, -(k + 1))) begin
                nerr++; $display("FAIL bp_order[%0d]: got %h, expected %h", k, got[k], po(k + 1, -(k + 1))); end
        end
        @(negedge clk);
        nvec++; if (out_count !== 16'd4 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_done: got cnt=%0d valid=%b, expected 4 0", out_count, out_valid); end
    endtask

    task automatic test_drain();
        int ndone, hs, dc; bit ir_bad; logic [CH*OUT_W-1:0] od;
        ndone = 0; hs = -1; dc = -1; ir_bad = 0; od = '0;
        @(posedge clk); #1 in_data = pk(160, -160); mode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0; start_conv = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin hs = c; od = out_data; end
            if (done) begin ndone++; dc = c; end
            if (c > 0 && in_ready) ir_bad = 1;
            @(posedge clk); #1;
        end
        nvec++; if (hs !== 4 || od !== po(10, -10)) begin
            nerr++; $display("FAIL drain_beat: got cycle %0d data %h, expected 4 %h", hs, od, po(10, -10)); end
        nvec++; if (ndone !== 1) begin nerr++; $display("FAIL drain_done_cnt: got %0d pulses, expected 1", ndone); end
        nvec++; if (dc !== hs + 1) begin nerr++; $display("FAIL drain_done_pos: got cycle %0d, expected %0d", dc, hs + 1); end
        nvec++; if (ir_bad !== 1'b0) begin nerr++; $display("FAIL drain_ready: got in_ready high, expected low"); end
    endtask

    task automatic test_clear();
        @(posedge clk); #1 start_conv = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; mode = 2'b00; in_data = pk(-2000000, 2000000);
        repeat (5) @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL clr_ready: got %b, expected 0", in_ready); end
        nvec++; if (out_count === '0 || out_valid !== 1'b1) begin
            nerr++; $display("FAIL clr_pre: got cnt=%0d valid=%b, expected nonzero 1", out_count, out_valid); end
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        nvec++; if (out_valid !== 1'b0 || out_count !== '0 || sat_flag !== '0) begin
            nerr++; $display("FAIL clr_post: got v=%b cnt=%0d sf=%b, expected 0 0 00", out_valid, out_count, sat_flag); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL clr_idle: got in_ready %b, expected 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [CH*OUT_W-1:0] od; logic [CH-1:0] sf; int lat; bit stale;
        stale = 0;
        xfer(pk(16, 16), 2'b00, 0, od, sf, lat);
        @(posedge clk); #1 in_data = pk(-2000000, 2000000); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nvec++; if (out_valid !== 1'b1 || sat_flag !== 2'b11 || out_count !== 16'd1) begin
            nerr++; $display("FAIL ar_pre: got v=%b sf=%b cnt=%0d, expected 1 11 1", out_valid, sat_flag, out_count); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0 || out_data !== '0) begin
            nerr++; $display("FAIL ar_data: got v=%b d=%h, expected 0 0", out_valid, out_data); end
        nvec++; if (sat_flag !== '0 || out_count !== '0 || in_ready !== 1'b0) begin
            nerr++; $display("FAIL ar_ctl: got sf=%b cnt=%0d r=%b, expected 00 0 0", sat_flag, out_count, in_ready); end
        #1 rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        nvec++; if (stale !== 1'b0) begin nerr++; $display("FAIL ar_stale: got a beat after reset, expected none"); end
        xfer(pk(16, 16), 2'b00, 0, od, sf, lat);
        nvec++; if (od !== po(1, 1) || lat !== 2) begin
            nerr++; $display("FAIL ar_resume: got %h lat %0d, expected %h lat 2", od, lat, po(1, 1)); end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_saturation();
        test_leaky();
        test_clamp();
        test_backpressure();
        test_drain();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
